// File: rtl/definitions_pkg.sv
// Shared sizing, read-FSM state type and column arithmetic for the 3x3 line-buffer window path.
package definitions_pkg;

   localparam int IMAGE_WIDTH      = 8;
   localparam int NUM_LINE_BUFFERS = 4;
   localparam int WINDOW_ROWS      = 3;

   localparam int PIXEL_W        = 8;
   localparam int TAP_W          = WINDOW_ROWS * PIXEL_W;
   localparam int WINDOW_W       = WINDOW_ROWS * TAP_W;
   localparam int COL_W          = $clog2(IMAGE_WIDTH);
   localparam int IDX_W          = $clog2(NUM_LINE_BUFFERS);
   localparam int FILL_MAX       = NUM_LINE_BUFFERS * IMAGE_WIDTH;
   localparam int FILL_W         = $clog2(FILL_MAX + 1);
   localparam int READ_THRESHOLD = WINDOW_ROWS * IMAGE_WIDTH;

   typedef enum logic {IDLE, READ} rd_state_t;

   // Next column within one line, wrapping at the line end.
   function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] col);
      return (col == COL_W'(IMAGE_WIDTH - 1)) ? '0 : col + COL_W'(1);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage; presents three horizontally adjacent pixels starting at the read
// pointer, the taps wrapping within the line.
module line_buffer
   import definitions_pkg::*;
(
   input  logic               clk,
   input  logic               rstN,
   input  logic [PIXEL_W-1:0] i_data,
   input  logic               i_data_valid,
   input  logic               i_rd_data,
   output logic [TAP_W-1:0]   o_data
);

   logic [PIXEL_W-1:0] line_mem [IMAGE_WIDTH];
   logic [COL_W-1:0]   wr_ptr_reg;
   logic [COL_W-1:0]   rd_ptr_reg;
   logic [COL_W-1:0]   tap1;
   logic [COL_W-1:0]   tap2;

   always_ff @(posedge clk) begin
      if (i_data_valid) begin
         line_mem[wr_ptr_reg] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (i_data_valid) begin
            wr_ptr_reg <= col_inc(wr_ptr_reg);
         end
         if (i_rd_data) begin
            rd_ptr_reg <= col_inc(rd_ptr_reg);
         end
      end
   end

   assign tap1   = col_inc(rd_ptr_reg);
   assign tap2   = col_inc(tap1);
   assign o_data = {line_mem[rd_ptr_reg], line_mem[tap1], line_mem[tap2]};

endmodule

// File: rtl/line_buffer_ctrl.sv
// Rotating four-line buffer: writes fill one line at a time, reads stream a 3x3 window from the
// three oldest lines while the fourth keeps accepting pixels.
module line_buffer_ctrl
   import definitions_pkg::*;
(
   input  logic                clk,
   input  logic                rstN,
   input  logic [PIXEL_W-1:0]  i_pixel_data,
   input  logic                i_pixel_valid,
   output logic [WINDOW_W-1:0] o_window,
   output logic                o_window_valid,
   output logic                o_intr,
   output logic                o_overflow
);

   rd_state_t          state_reg, state_next;
   logic [COL_W-1:0]   wr_col_reg, wr_col_next;
   logic [IDX_W-1:0]   wr_idx_reg, wr_idx_next;
   logic [COL_W-1:0]   rd_col_reg, rd_col_next;
   logic [IDX_W-1:0]   rd_idx_reg, rd_idx_next;
   logic [FILL_W-1:0]  fill_reg, fill_next;
   logic               intr_reg, intr_next;
   logic               overflow_reg, overflow_next;

   logic               rd_active;
   logic               accept;
   logic [NUM_LINE_BUFFERS-1:0] wr_en;
   logic [NUM_LINE_BUFFERS-1:0] rd_en;
   logic [TAP_W-1:0]   lb_data [NUM_LINE_BUFFERS];
   logic [WINDOW_W-1:0] window;

   generate
      for (genvar gi = 0; gi < NUM_LINE_BUFFERS; gi++) begin : g_lb
         logic [IDX_W-1:0] rel_idx;

         // Distance from the oldest line being read; the window covers the next WINDOW_ROWS lines.
         assign rel_idx   = IDX_W'(gi) - rd_idx_reg;
         assign wr_en[gi] = accept && (wr_idx_reg == IDX_W'(gi));
         assign rd_en[gi] = rd_active && (rel_idx < IDX_W'(WINDOW_ROWS));

         line_buffer u_lb (
            .clk          (clk),
            .rstN         (rstN),
            .i_data       (i_pixel_data),
            .i_data_valid (wr_en[gi]),
            .i_rd_data    (rd_en[gi]),
            .o_data       (lb_data[gi])
         );
      end
   endgenerate

   always_comb begin
      rd_active     = (state_reg == READ);
      accept        = i_pixel_valid && ((fill_reg != FILL_W'(FILL_MAX)) || rd_active);
      overflow_next = overflow_reg || (i_pixel_valid && !accept);

      wr_col_next = wr_col_reg;
      wr_idx_next = wr_idx_reg;
      if (accept) begin
         if (wr_col_reg == COL_W'(IMAGE_WIDTH - 1)) begin
            wr_col_next = '0;
            wr_idx_next = wr_idx_reg + IDX_W'(1);
         end else begin
            wr_col_next = wr_col_reg + COL_W'(1);
         end
      end

      fill_next = fill_reg;
      if (accept && !rd_active) begin
         fill_next = fill_reg + FILL_W'(1);
      end else if (!accept && rd_active) begin
         fill_next = fill_reg - FILL_W'(1);
      end
   end

   always_comb begin
      state_next  = state_reg;
      rd_col_next = rd_col_reg;
      rd_idx_next = rd_idx_reg;
      intr_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            // Looking at the post-edge fill lets the window open right after the third line lands.
            if (fill_next >= FILL_W'(READ_THRESHOLD)) begin
               state_next = READ;
            end
         end
         READ: begin
            if (rd_col_reg == COL_W'(IMAGE_WIDTH - 1)) begin
               rd_col_next = '0;
               rd_idx_next = rd_idx_reg + IDX_W'(1);
               intr_next   = 1'b1;
               state_next  = IDLE;
            end else begin
               rd_col_next = rd_col_reg + COL_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg    <= IDLE;
         wr_col_reg   <= '0;
         wr_idx_reg   <= '0;
         rd_col_reg   <= '0;
         rd_idx_reg   <= '0;
         fill_reg     <= '0;
         intr_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wr_col_reg   <= wr_col_next;
         wr_idx_reg   <= wr_idx_next;
         rd_col_reg   <= rd_col_next;
         rd_idx_reg   <= rd_idx_next;
         fill_reg     <= fill_next;
         intr_reg     <= intr_next;
         overflow_reg <= overflow_next;
      end
   end

   // Oldest row occupies the top slice; rows outside READ are forced to zero.
   always_comb begin
      window = '0;
      if (rd_active) begin
         for (int r = 0; r < WINDOW_ROWS; r++) begin
            window[(WINDOW_ROWS - 1 - r) * TAP_W +: TAP_W] = lb_data[rd_idx_reg + IDX_W'(r)];
         end
      end
   end

   assign o_window       = window;
   assign o_window_valid = rd_active;
   assign o_intr         = intr_reg;
   assign o_overflow     = overflow_reg;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: segment tables of expected window/intr activity for
// streamed lines, plus hand sequences for mid-read reset and the full-buffer corners.
module tb_line_buffer_ctrl;
   import definitions_pkg::*;

   localparam int W = IMAGE_WIDTH;

   logic                clk = 1'b0;
   logic                rstN = 1'b0;
   logic [PIXEL_W-1:0]  pix_data = '0;
   logic                pix_valid = 1'b0;
   logic [WINDOW_W-1:0] window;
   logic                window_valid;
   logic                intr;
   logic                overflow;

   int errors = 0;
   int checks = 0;
   int probe_cyc = -1;
   int probe_fill = 0;

   typedef struct {
      int len;
      bit exp_wv;
      bit exp_intr;
      int base_line;
   } seg_t;

   seg_t plan[$];

   line_buffer_ctrl dut (
      .clk            (clk),
      .rstN           (rstN),
      .i_pixel_data   (pix_data),
      .i_pixel_valid  (pix_valid),
      .o_window       (window),
      .o_window_valid (window_valid),
      .o_intr         (intr),
      .o_overflow     (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pix(input int line, input int col);
      return 8'((16 * line + col) % 256);
   endfunction

   function automatic logic [23:0] row_exp(input int line, input int col);
      return {pix(line, col), pix(line, (col + 1) % W), pix(line, (col + 2) % W)};
   endfunction

   function automatic logic [71:0] win_exp(input int base, input int col);
      return {row_exp(base, col), row_exp(base + 1, col), row_exp(base + 2, col)};
   endfunction

   task automatic chk(input string name, input int cyc, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Streams n_pix pixels from cycle 0 and checks every cycle against the segment plan.
   task automatic run_plan(input string tag, input int n_pix, input int line_ofs);
      int t = 0;
      foreach (plan[s]) begin
         $display("[%s] seg %0d len=%0d wv=%0b intr=%0b base=%0d", tag, s, plan[s].len,
                  plan[s].exp_wv, plan[s].exp_intr, plan[s].base_line + line_ofs);
         for (int k = 0; k < plan[s].len; k++) begin
            pix_valid = (t < n_pix);
            pix_data  = pix(line_ofs + t / W, t % W);
            @(negedge clk);
            chk({tag, " window_valid"}, t, 72'(window_valid), 72'(plan[s].exp_wv));
            chk({tag, " intr"}, t, 72'(intr), 72'(plan[s].exp_intr));
            chk({tag, " overflow"}, t, 72'(overflow), 72'(0));
            chk({tag, " window"}, t, window,
                plan[s].exp_wv ? win_exp(plan[s].base_line + line_ofs, k) : 72'(0));
            if (t == probe_cyc) begin
               chk({tag, " fill"}, t, 72'(dut.fill_reg), 72'(probe_fill));
            end
            @(posedge clk);
            #1;
            t++;
         end
      end
      pix_valid = 1'b0;
      plan.delete();
      probe_cyc = -1;
   endtask

   initial begin
      // Reset state
      #1;
      chk("reset window_valid", 0, 72'(window_valid), 72'(0));
      chk("reset intr", 0, 72'(intr), 72'(0));
      chk("reset overflow", 0, 72'(overflow), 72'(0));
      chk("reset window", 0, window, 72'(0));
      do_reset();
      chk("reset fill", 0, 72'(dut.fill_reg), 72'(0));

      // Three lines then idle: one window of W cycles from LB0..LB2, one intr, then quiet.
      plan.push_back('{3 * W, 1'b0, 1'b0, 0});
      plan.push_back('{W,     1'b1, 1'b0, 0});
      plan.push_back('{1,     1'b0, 1'b1, 0});
      plan.push_back('{6,     1'b0, 1'b0, 0});
      run_plan("three_lines", 3 * W, 0);

      // Six lines back to back: line 3 written during first READ, wr_idx wraps, four windows.
      do_reset();
      plan.push_back('{3 * W, 1'b0, 1'b0, 0});
      plan.push_back('{W,     1'b1, 1'b0, 0});
      plan.push_back('{1,     1'b0, 1'b1, 0});
      plan.push_back('{W,     1'b1, 1'b0, 1});
      plan.push_back('{1,     1'b0, 1'b1, 0});
      plan.push_back('{W,     1'b1, 1'b0, 2});
      plan.push_back('{1,     1'b0, 1'b1, 0});
      plan.push_back('{W,     1'b1, 1'b0, 3});
      plan.push_back('{1,     1'b0, 1'b1, 0});
      plan.push_back('{5,     1'b0, 1'b0, 0});
      probe_cyc  = 4 * W;
      probe_fill = 3 * W;
      run_plan("six_lines", 6 * W, 0);

      // Reset in the middle of a READ, then a clean restart with fresh line content.
      do_reset();
      plan.push_back('{3 * W, 1'b0, 1'b0, 0});
      plan.push_back('{W / 2, 1'b1, 1'b0, 0});
      run_plan("pre_reset", 3 * W, 0);
      chk("midread window_valid before reset", 0, 72'(window_valid), 72'(1));
      rstN = 1'b0;
      #1;
      $display("[mid_reset] rstN asserted at read column %0d", W / 2);
      chk("midread reset window_valid", 0, 72'(window_valid), 72'(0));
      chk("midread reset window", 0, window, 72'(0));
      chk("midread reset intr", 0, 72'(intr), 72'(0));
      chk("midread reset overflow", 0, 72'(overflow), 72'(0));
      chk("midread reset fill", 0, 72'(dut.fill_reg), 72'(0));
      do_reset();
      plan.push_back('{3 * W, 1'b0, 1'b0, 0});
      plan.push_back('{W,     1'b1, 1'b0, 0});
      plan.push_back('{1,     1'b0, 1'b1, 0});
      plan.push_back('{3,     1'b0, 1'b0, 0});
      run_plan("after_reset", 3 * W, 10);

      // Continuous stream: fill climbs one per window period until it hits 4W during a READ,
      // then the next intr-cycle pixel has nowhere to go.
      do_reset();
      for (int t = 0; t < 140; t++) begin
         pix_valid = (t < 120);
         pix_data  = 8'(t);
         @(negedge clk);
         if (t == 96) begin
            $display("[full] cyc=%0d read at full buffer", t);
            chk("full read window_valid", t, 72'(window_valid), 72'(1));
            chk("full read fill", t, 72'(dut.fill_reg), 72'(FILL_MAX));
         end
         if (t == 104) begin
            $display("[full] cyc=%0d intr cycle at full buffer", t);
            chk("full intr", t, 72'(intr), 72'(1));
            chk("full after read fill", t, 72'(dut.fill_reg), 72'(FILL_MAX));
            chk("full after read overflow", t, 72'(overflow), 72'(0));
         end
         if (t == 105) begin
            $display("[full] cyc=%0d pixel dropped", t);
            chk("drop overflow", t, 72'(overflow), 72'(1));
            chk("drop fill", t, 72'(dut.fill_reg), 72'(FILL_MAX));
         end
         if (t == 139) begin
            $display("[full] cyc=%0d overflow hold", t);
            chk("overflow held", t, 72'(overflow), 72'(1));
         end
         @(posedge clk);
         #1;
      end
      pix_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
